mul4_limb_sequencer: RTL

- Multi-cycle unsigned 32x32 -> 64 multiplier; operands and result carried as 16-bit limbs (a1:a0, b1:b0 -> y3:y2:y1:y0).
- Time-shares one 16x16 limb multiplier across the four partial products and accumulates them into a 64-bit register.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Acts as the scheduler for the mul4 vector datapath, in place of a fully parallel combinational multiplier.

---
 rtl/mul4_pkg.sv | 49 ++++
 rtl/mul4_limb_mul.sv | 19 +
 rtl/mul4_limb_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mul4_pkg.sv
// rtl/mul4_pkg.sv - shared types, constants and step table for the mul4 limb sequencer
//
// Contents:
//   LIMB_W_DEF  default limb width (16)
//   state_t     IDLE / MUL / DONE
//   step_t      2-bit partial-product step index
//   STEP_TBL    per-step limb selects and shift (in limbs)
//   find_step   lowest set step at or above a start index in a step mask
package mul4_pkg;

    localparam int LIMB_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    // a_hi/b_hi pick the high limb of each operand; shift_limbs is the
    // partial-product weight expressed in whole limbs.
    typedef struct packed {
        logic       a_hi;
        logic       b_hi;
        logic [1:0] shift_limbs;
    } step_cfg_t;

    localparam step_cfg_t [0:3] STEP_TBL = '{
        '{a_hi: 1'b0, b_hi: 1'b0, shift_limbs: 2'd0},   // a0*b0
        '{a_hi: 1'b0, b_hi: 1'b1, shift_limbs: 2'd1},   // a0*b1
        '{a_hi: 1'b1, b_hi: 1'b0, shift_limbs: 2'd1},   // a1*b0
        '{a_hi: 1'b1, b_hi: 1'b1, shift_limbs: 2'd2}    // a1*b1
    };

    // Returns {found, step}: the lowest set bit of mask whose index is >= from.
    // from may be 4, meaning "past the last step", which yields found = 0.
    function automatic logic [2:0] find_step(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if ((3'(i) >= from) && mask[i]) begin
                r = {1'b1, step_t'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul4_limb_mul.sv
// rtl/mul4_limb_mul.sv - combinational unsigned LIMB_W x LIMB_W -> 2*LIMB_W multiplier
//
// Ports:
//   a, b  in   LIMB_W     unsigned limb operands
//   p     out  2*LIMB_W   full-width product
module mul4_limb_mul
    import mul4_pkg::*;
#(
    parameter int LIMB_W = LIMB_W_DEF
) (
    input  logic [LIMB_W-1:0]   a,
    input  logic [LIMB_W-1:0]   b,
    output logic [2*LIMB_W-1:0] p
);

    // Zero-extend first so the product is formed at full width.
    assign p = {{LIMB_W{1'b0}}, a} * {{LIMB_W{1'b0}}, b};

endmodule

// File: rtl/mul4_limb_sequencer.sv
// rtl/mul4_limb_sequencer.sv - multi-cycle 32x32->64 multiplier sharing one limb multiplier
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a1, a0, b1, b0       operand limbs, sampled only in the accept cycle
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   y3..y0               64-bit product, y3 most significant; zero outside DONE
//   busy                 high in MUL or DONE
//
// Build option: MUL4_SKIP_ZERO_EN - skip partial products with a zero limb,
// shortening latency to 1 + (number of nonzero pairs). Result is unchanged.
module mul4_limb_sequencer
    import mul4_pkg::*;
#(
    parameter int LIMB_W = LIMB_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LIMB_W-1:0] a1,
    input  logic [LIMB_W-1:0] a0,
    input  logic [LIMB_W-1:0] b1,
    input  logic [LIMB_W-1:0] b0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LIMB_W-1:0] y3,
    output logic [LIMB_W-1:0] y2,
    output logic [LIMB_W-1:0] y1,
    output logic [LIMB_W-1:0] y0,
    output logic              busy
);

    localparam int OP_W  = 2 * LIMB_W;
    localparam int ACC_W = 4 * LIMB_W;

    state_t            state_r, state_nxt;
    step_t             step_r, step_nxt;
    logic [OP_W-1:0]   a_r, b_r;
    logic [ACC_W-1:0]  acc_r;
    logic              load, acc_upd;

    // Step masks: mask_in is evaluated on the live operands at accept,
    // mask_cur is the mask governing the transaction in flight.
    logic [3:0] mask_in, mask_cur;

`ifdef MUL4_SKIP_ZERO_EN
    logic [3:0] mask_r;

    assign mask_in[0] = (a0 != '0) && (b0 != '0);
    assign mask_in[1] = (a0 != '0) && (b1 != '0);
    assign mask_in[2] = (a1 != '0) && (b0 != '0);
    assign mask_in[3] = (a1 != '0) && (b1 != '0);
    assign mask_cur   = mask_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r <= '0;
        end else if (load) begin
            mask_r <= mask_in;
        end
    end
`else
    assign mask_in  = 4'hF;
    assign mask_cur = 4'hF;
`endif

    // Limb selection for the current step.
    step_cfg_t           cfg;
    logic [LIMB_W-1:0]   op_a, op_b;
    logic [OP_W-1:0]     pp;
    logic [ACC_W-1:0]    pp_ext, term;

    assign cfg  = STEP_TBL[step_r];
    assign op_a = cfg.a_hi ? a_r[OP_W-1:LIMB_W] : a_r[LIMB_W-1:0];
    assign op_b = cfg.b_hi ? b_r[OP_W-1:LIMB_W] : b_r[LIMB_W-1:0];

    mul4_limb_mul #(.LIMB_W(LIMB_W)) u_limb_mul (
        .a (op_a),
        .b (op_b),
        .p (pp)
    );

    assign pp_ext = {{OP_W{1'b0}}, pp};

    always_comb begin
        term = pp_ext;
        case (cfg.shift_limbs)
            2'd0:    term = pp_ext;
            2'd1:    term = pp_ext << LIMB_W;
            default: term = pp_ext << (2 * LIMB_W);
        endcase
    end

    // Next-state logic.
    logic [2:0] first_step, next_step;

    assign first_step = find_step(mask_in, 3'd0);
    assign next_step  = find_step(mask_cur, {1'b0, step_r} + 3'd1);

    always_comb begin
        state_nxt = state_r;
        step_nxt  = step_r;
        load      = 1'b0;
        acc_upd   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                    if (first_step[2]) begin
                        state_nxt = MUL;
                        step_nxt  = first_step[1:0];
                    end else begin
                        // Every pair skipped: the cleared accumulator is the answer.
                        state_nxt = DONE;
                    end
                end
            end
            MUL: begin
                acc_upd = 1'b1;
                if (next_step[2]) begin
                    step_nxt = next_step[1:0];
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            step_r  <= '0;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
        end else begin
            state_r <= state_nxt;
            step_r  <= step_nxt;
            if (load) begin
                a_r   <= {a1, a0};
                b_r   <= {b1, b0};
                acc_r <= '0;
            end else if (acc_upd) begin
                acc_r <= acc_r + term;
            end
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);

    // Result is exposed only while it is being offered.
    assign {y3, y2, y1, y0} = out_valid ? acc_r : '0;

endmodule
